// File: rtl/nn1_pkg.sv
// -----------------------------------------------------------------------------
// nn1_pkg
// Shared constants and the scheduler state encoding for the nn1 network.
// No ports.
// -----------------------------------------------------------------------------
package nn1_pkg;

  localparam int NN1_OUTPUT_NEURONS = 10;   // output-layer neurons per inference
  localparam int NN1_OUTPUT_BIT     = 8;    // width of the shared neuron result
  localparam int NN1_HIDDEN_LAYER   = 100;  // hidden-layer neurons feeding layer 2

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/nn1_argmax_tracker.sv
// -----------------------------------------------------------------------------
// nn1_argmax_tracker
// Running argmax over the output-layer scores.
// Ports:
//   clk3            in   clock
//   reset1          in   asynchronous active-high reset
//   load_first      in   load idx/score unconditionally
//   load_cmp        in   load idx/score only if score > max_score (unsigned)
//   idx             in   [3:0] index that goes with score
//   score           in   [OUTPUT_BIT-1:0] candidate score
//   predicted_class out  [3:0] index of the best score so far
//   max_score       out  [OUTPUT_BIT-1:0] best score so far
// -----------------------------------------------------------------------------
module nn1_argmax_tracker
  import nn1_pkg::*;
#(
  parameter int OUTPUT_BIT = NN1_OUTPUT_BIT
) (
  input  logic                  clk3,
  input  logic                  reset1,
  input  logic                  load_first,
  input  logic                  load_cmp,
  input  logic [3:0]            idx,
  input  logic [OUTPUT_BIT-1:0] score,
  output logic [3:0]            predicted_class,
  output logic [OUTPUT_BIT-1:0] max_score
);

  // Strict compare: equal scores keep the earlier (lower) index.
  logic w_better;
  assign w_better = score > max_score;

  always_ff @(posedge clk3 or posedge reset1) begin
    if (reset1) begin
      predicted_class <= '0;
      max_score       <= '0;
    end else if (load_first || (load_cmp && w_better)) begin
      predicted_class <= idx;
      max_score       <= score;
    end
  end

endmodule

// File: rtl/nn1_layer2_scheduler.sv
// -----------------------------------------------------------------------------
// nn1_layer2_scheduler
// Sequences the shared neuron over every output-layer row and reports argmax.
// Ports:
//   clk3            in   clock, rising edge
//   reset1          in   asynchronous active-high reset
//   start           in   request one inference (sampled in IDLE only)
//   neuron_out      in   [OUTPUT_BIT-1:0] ReLU result from the shared neuron
//   weight_addr     out  [3:0] weight/bias ROM row = current neuron index
//   neuron_clr      out  accumulator clear (CLEAR state)
//   neuron_en       out  compute strobe (ISSUE state)
//   busy            out  high in every state except IDLE
//   done            out  one-cycle pulse when the result is final
//   predicted_class out  [3:0] argmax index
//   max_score       out  [OUTPUT_BIT-1:0] score at the argmax
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | clear neuron accumulator for row r_idx
// ISSUE   | one-cycle compute strobe
// WAIT    | NEURON_LAT cycles for neuron_out to settle
// CAPTURE | fold neuron_out into the argmax, advance or finish
// DONE    | done pulse, back to IDLE
// -----------------------------------------------------------------------------
module nn1_layer2_scheduler
  import nn1_pkg::*;
#(
  parameter int OUTPUT_NEURONS = NN1_OUTPUT_NEURONS,
  parameter int OUTPUT_BIT     = NN1_OUTPUT_BIT,
  parameter int NEURON_LAT     = 1
) (
  input  logic                  clk3,
  input  logic                  reset1,
  input  logic                  start,
  input  logic [OUTPUT_BIT-1:0] neuron_out,
  output logic [3:0]            weight_addr,
  output logic                  neuron_clr,
  output logic                  neuron_en,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            predicted_class,
  output logic [OUTPUT_BIT-1:0] max_score
);

  localparam int         WW       = (NEURON_LAT > 1) ? $clog2(NEURON_LAT) : 1;
  localparam logic [3:0] LAST_IDX = 4'(OUTPUT_NEURONS - 1);

  state_t          r_state;
  logic [3:0]      r_idx;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_clr;
  logic            r_en;
  logic            r_busy;
  logic            r_done;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_load_first;
  logic                  w_load_cmp;
  logic [3:0]            w_trk_idx;
  logic [OUTPUT_BIT-1:0] w_trk_score;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_capture = (r_state == ST_CAPTURE);

  // An accepted start reuses the unconditional load path with a zero score
  // and index 0, which clears the previous result without a separate port.
  assign w_load_first = w_accept || (w_capture && (r_idx == 4'd0));
  assign w_load_cmp   = w_capture && (r_idx != 4'd0);
  assign w_trk_idx    = w_accept ? 4'd0 : r_idx;
  assign w_trk_score  = w_accept ? '0 : neuron_out;

  always_ff @(posedge clk3 or posedge reset1) begin
    if (reset1) begin
      r_state    <= ST_IDLE;
      r_idx      <= 4'd0;
      r_wait_cnt <= '0;
      r_clr      <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_clr  <= 1'b0;
      r_en   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_CLEAR;
            r_idx   <= 4'd0;
            r_clr   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_ISSUE;
          r_en    <= 1'b1;
        end
        ST_ISSUE: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= WW'(NEURON_LAT - 1);
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (r_idx < LAST_IDX) begin
            r_state <= ST_CLEAR;
            r_idx   <= r_idx + 4'd1;
            r_clr   <= 1'b1;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  nn1_argmax_tracker #(
    .OUTPUT_BIT (OUTPUT_BIT)
  ) u_argmax (
    .clk3            (clk3),
    .reset1          (reset1),
    .load_first      (w_load_first),
    .load_cmp        (w_load_cmp),
    .idx             (w_trk_idx),
    .score           (w_trk_score),
    .predicted_class (predicted_class),
    .max_score       (max_score)
  );

  assign weight_addr = r_idx;
  assign neuron_clr  = r_clr;
  assign neuron_en   = r_en;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_nn1_layer2_scheduler.sv
module tb_nn1_layer2_scheduler;

  localparam int N = 10;

  logic       clk3;
  logic       reset1;
  logic       start;
  logic [7:0] nout  [2];
  logic [3:0] addr  [2];
  logic       clr   [2];
  logic       en    [2];
  logic       busy  [2];
  logic       done  [2];
  logic [3:0] pc    [2];
  logic [7:0] ms    [2];

  // Instance 0 uses NEURON_LAT=1, instance 1 uses NEURON_LAT=3.
  nn1_layer2_scheduler #(.OUTPUT_NEURONS(10), .OUTPUT_BIT(8), .NEURON_LAT(1)) dut0 (
    .clk3(clk3), .reset1(reset1), .start(start), .neuron_out(nout[0]),
    .weight_addr(addr[0]), .neuron_clr(clr[0]), .neuron_en(en[0]), .busy(busy[0]),
    .done(done[0]), .predicted_class(pc[0]), .max_score(ms[0]));

  nn1_layer2_scheduler #(.OUTPUT_NEURONS(10), .OUTPUT_BIT(8), .NEURON_LAT(3)) dut1 (
    .clk3(clk3), .reset1(reset1), .start(start), .neuron_out(nout[1]),
    .weight_addr(addr[1]), .neuron_clr(clr[1]), .neuron_en(en[1]), .busy(busy[1]),
    .done(done[1]), .predicted_class(pc[1]), .max_score(ms[1]));

  initial begin
    clk3 = 1'b0;
    forever #5 clk3 = ~clk3;
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Scores the neuron model returns, by row.
  logic [7:0] sc [N];

  // Neuron model: output is 8'hFF (a value that would win the argmax) until
  // NEURON_LAT edges after the strobe rises, then the row's score.
  int ncnt [2];
  initial begin
    nout[0] = 8'h00;
    nout[1] = 8'h00;
    ncnt[0] = 0;
    ncnt[1] = 0;
    forever begin
      @(posedge clk3);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (reset1) begin
          ncnt[d] = 0;
        end else if (clr[d]) begin
          nout[d] = 8'hFF;
        end else if (en[d]) begin
          ncnt[d] = lat(d);
          nout[d] = 8'hFF;
        end else if (ncnt[d] > 0) begin
          ncnt[d] = ncnt[d] - 1;
          if (ncnt[d] == 0) nout[d] = sc[addr[d]];
        end
      end
    end
  end

  // Model and bookkeeping (single process owns all of it).
  int         cyc;
  bit         act      [2];
  int         s_edge   [2];
  logic [3:0] e_pc     [2];
  logic [7:0] e_ms     [2];
  int         done_cnt [2];
  int         clr_cnt  [2];
  int         en_cnt   [2];
  int         last_done[2];
  int         gap      [2];
  int         n_chk;
  int         n_pass;

  task automatic chk(input string nm, input int d, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s dut%0d at edge %0d: got %0d expected %0d", nm, d, cyc, got, exp);
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk3);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int tt;
      tt = N * (3 + lat(d));
      if (reset1) act[d] = 1'b0;
      else if (act[d] && (cyc == s_edge[d] + tt + 1)) act[d] = 1'b0;
      else if (!act[d] && start) begin
        act[d]    = 1'b1;
        s_edge[d] = cyc;
      end
    end
    @(negedge clk3);
    for (int d = 0; d < 2; d++) begin
      int p, tt, m, ncap, bi;
      logic [7:0] best;
      logic xb, xd, xc, xe;
      p  = 3 + lat(d);
      tt = N * p;
      if (reset1) begin
        e_pc[d] = 4'd0;
        e_ms[d] = 8'd0;
        chk("rst_busy", d, busy[d], 0);
        chk("rst_done", d, done[d], 0);
        chk("rst_clr",  d, clr[d],  0);
        chk("rst_en",   d, en[d],   0);
        chk("rst_addr", d, addr[d], 0);
        chk("rst_pc",   d, pc[d],   0);
        chk("rst_ms",   d, ms[d],   0);
      end else begin
        xb = 0; xd = 0; xc = 0; xe = 0;
        if (act[d]) begin
          m = cyc - s_edge[d];
          xb = 1;
          if (m < tt) begin
            xc = ((m % p) == 0);
            xe = ((m % p) == 1);
            chk("weight_addr", d, addr[d], m / p);
          end else begin
            xd = 1;
          end
          // Rows whose capture edge has passed have been folded in.
          ncap = m / p;
          best = 8'd0;
          bi   = 0;
          for (int i = 0; i < ncap; i++) begin
            if (i == 0 || sc[i] > best) begin
              best = sc[i];
              bi   = i;
            end
          end
          e_pc[d] = 4'(bi);
          e_ms[d] = best;
        end
        chk("busy",       d, busy[d], xb);
        chk("done",       d, done[d], xd);
        chk("neuron_clr", d, clr[d],  xc);
        chk("neuron_en",  d, en[d],   xe);
        chk("pred_class", d, pc[d],   e_pc[d]);
        chk("max_score",  d, ms[d],   e_ms[d]);
      end
      if (done[d]) begin
        done_cnt[d]++;
        gap[d]       = cyc - last_done[d];
        last_done[d] = cyc;
      end
      if (clr[d]) clr_cnt[d]++;
      if (en[d])  en_cnt[d]++;
    end
  endtask

  task automatic run_check(input int xpc, input int xms);
    int dc[2], cc[2], ec[2];
    int t0;
    for (int d = 0; d < 2; d++) begin
      dc[d] = done_cnt[d];
      cc[d] = clr_cnt[d];
      ec[d] = en_cnt[d];
    end
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    for (int k = 0; k < 200 && done_cnt[1] == dc[1]; k++) tick();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("done_latency", d, last_done[d] - t0, (d == 0) ? 40 : 60);
      chk("done_pulses",  d, done_cnt[d] - dc[d], 1);
      chk("clr_pulses",   d, clr_cnt[d] - cc[d], 10);
      chk("en_pulses",    d, en_cnt[d] - ec[d], 10);
      chk("final_pc",     d, pc[d], xpc);
      chk("final_ms",     d, ms[d], xms);
    end
  endtask

  initial begin
    int dc[2];
    int t0;
    cyc    = 0;
    n_chk  = 0;
    n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; s_edge[d] = 0; e_pc[d] = 0; e_ms[d] = 0;
      done_cnt[d] = 0; clr_cnt[d] = 0; en_cnt[d] = 0; last_done[d] = 0; gap[d] = 0;
    end
    for (int i = 0; i < N; i++) sc[i] = 8'd0;
    reset1 = 1'b1;
    start  = 1'b0;
    repeat (3) tick();
    reset1 = 1'b0;
    repeat (2) tick();

    sc = '{8'd5, 8'd9, 8'd3, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    run_check(1, 9);

    sc = '{default: 8'd0};
    run_check(0, 0);

    sc = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};
    run_check(9, 19);

    sc = '{8'd255, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254};
    run_check(0, 255);

    // Start held for 100 edges: dut0 accepts at +0,+42,+84, dut1 at +0,+62.
    sc = '{8'd5, 8'd9, 8'd3, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    dc[0] = done_cnt[0];
    dc[1] = done_cnt[1];
    start = 1'b1;
    repeat (100) tick();
    start = 1'b0;
    for (int k = 0; k < 300 && (act[0] || act[1]); k++) tick();
    repeat (2) tick();
    chk("held_dones", 0, done_cnt[0] - dc[0], 3);
    chk("held_dones", 1, done_cnt[1] - dc[1], 2);
    chk("held_gap",   0, gap[0], 42);
    chk("held_gap",   1, gap[1], 62);
    chk("held_pc",    0, pc[0], 1);
    chk("held_ms",    1, ms[1], 9);

    // Reset after edge 17 of a run: no done, outputs cleared.
    sc = '{8'd7, 8'd2, 8'd7, 8'd8, 8'd1, 8'd8, 8'd3, 8'd0, 8'd0, 8'd4};
    dc[0] = done_cnt[0];
    dc[1] = done_cnt[1];
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    for (int k = 0; k < 40 && cyc < t0 + 17; k++) tick();
    reset1 = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("abort_busy", d, busy[d], 0);
      chk("abort_done", d, done[d], 0);
      chk("abort_pc",   d, pc[d], 0);
      chk("abort_ms",   d, ms[d], 0);
    end
    repeat (2) tick();
    reset1 = 1'b0;
    repeat (80) tick();
    chk("abort_no_done", 0, done_cnt[0] - dc[0], 0);
    chk("abort_no_done", 1, done_cnt[1] - dc[1], 0);
    run_check(3, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
